reg_file: RTL and testbench
===========================

# reg_file

Two-read/one-write general-purpose register file for the single-cycle datapath. It sits directly upstream of the ALU: it drives the ALU `a`/`b` operands and accepts the write-back result and the ALU `flag`. A sequenced debug scan port streams all register contents to the VGA display logic without disturbing datapath reads.

## Interface
- `DATA_W`, default 16: register and operand width; matches the ALU operand width.
- `ADDR_W`, default 4: register address width; `NUM_REGS = 2**ADDR_W` (16).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state.
- `ra_addr`  in  ADDR_W  read address, port A.
- `rb_addr`  in  ADDR_W  read address, port B.
- `a`  out  DATA_W  port A data, to ALU `a`.
- `b`  out  DATA_W  port B data, to ALU `b`.
- `we`  in  1  write enable.
- `wd_addr`  in  ADDR_W  write address.
- `wd`  in  DATA_W  write data, from ALU `Y` or memory.
- `flag_we`  in  1  capture enable for `flag_in`.
- `flag_in`  in  1  ALU flag.
- `flag`  out  1  registered flag, for branch logic.
- `dbg_req`  in  1  start-scan request; level is sampled at each edge.
- `dbg_busy`  out  1  scan in progress.
- `dbg_valid`  out  1  `dbg_idx`/`dbg_data` are valid this cycle.
- `dbg_idx`  out  ADDR_W  register index currently presented.
- `dbg_data`  out  DATA_W  contents of register `dbg_idx`.

## Operation
- R0 is hardwired to zero.
  - Reads of address 0 return 0.
  - Writes to address 0 are discarded.
- Reads are combinational from the array, with write-through bypass.
  - If `we`=1, `wd_addr`==`ra_addr`, and `ra_addr`!=0, then `a`=`wd`. Port B is bypassed the same way.
  - Both ports may read the same address at once.
- Write: at the rising edge with `we`=1 and `wd_addr`!=0, `reg[wd_addr]` <= `wd`.
- Flag: at the rising edge with `flag_we`=1, `flag` <= `flag_in`. Otherwise `flag` holds.
- The debug scan FSM has two states, IDLE and SCAN.
  - In IDLE, `dbg_req`=1 at an edge moves the FSM to SCAN, with scan counter = 0.
  - In SCAN, each edge presents `dbg_idx` = counter, `dbg_data` = `reg[counter]` taken from the array with no bypass, and `dbg_valid`=1. The counter then increments.
  - After index `NUM_REGS-1` is presented, the FSM returns to IDLE. The counter wraps to 0.
  - `dbg_req` is ignored while in SCAN; no re-queue. If `dbg_req` is still high on the edge after returning to IDLE, a new scan starts.
- Simultaneous write and scan of the same index: `dbg_data` shows the pre-write value. The new value appears on the next scan.
- Reset values, applied asynchronously:
  - all registers = 0;
  - `flag`=0;
  - FSM = IDLE, counter = 0;
  - `dbg_busy`=0, `dbg_valid`=0, `dbg_idx`=0, `dbg_data`=0.
  - `a`/`b` then read 0 unless bypass is active.
- Reset mid-scan aborts the scan immediately. No partial completion, and a new `dbg_req` is needed afterwards.

## Timing
- Read latency is 0 cycles (combinational). Write-to-read latency through the array is 1 edge, and 0 through the bypass.
- Flag capture latency is 1 edge.
- Scan timing when `dbg_req` is sampled high at edge N in IDLE:
  - `dbg_busy` and `dbg_valid` are high from after edge N+1 until edge N+17. That is exactly 16 cycles, with idx 0..15 in order.
  - `dbg_busy` falls together with `dbg_valid`.
  - Back-to-back scans with `dbg_req` held high have 1 idle cycle between them.
- `dbg_*` outputs are registered. No combinational path exists from `dbg_req` to any output.

## Structure
- Shared package `datapath_pkg` holds:
  - `DATA_W`, `ADDR_W`, `NUM_REGS`;
  - the scan state enum (`SCAN_IDLE`, `SCAN_RUN`).
- The ALU and the VGA text renderer import the same package.
- One sub-module, `reg_file_dbg_scan`, contains the FSM, the counter and the registered `dbg_*` outputs. It indexes the array through a third read address.
- The storage array, bypass muxes and flag register live in `reg_file`.

## Test plan
- Reset, then read all addresses -> `a`=`b`=0 and `flag`=0. Assert `rst` mid-run -> outputs clear without waiting for a clock edge.
- Write R3=15, then R5=11. Read `ra`=3, `rb`=5 -> `a`=15, `b`=11, as ALU operands for ops 0101/0110/0001/0111.
- Write R0=0xFFFF, then read R0 -> 0. With `we`=1, `wd_addr`=7, `wd`=0x1234, `ra_addr`=`rb_addr`=7 in the same cycle -> `a`=`b`=0x1234 (bypass). On the next cycle, with `we`=0 -> still 0x1234.
- `flag_we`=1, `flag_in`=1 at one edge, then `flag_we`=0, `flag_in`=0 at the next -> `flag` stays 1.
- Preload Rk=k·0x0101 (k=1..15) and pulse `dbg_req`.
  - Expect exactly 16 valid cycles with idx 0..15 and data 0, 0x0101 … 0x0F0F, with `busy` matching `valid`.
  - A second `dbg_req` during the scan is ignored.
  - Writing R4=0xBEEF in the cycle idx=4 is presented -> `dbg_data`=0x0404.
- Assert `rst` at idx=9 of a scan -> `dbg_valid` and `dbg_busy` are 0 asynchronously. After release, with no new request -> the FSM stays IDLE.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared datapath constants and the debug scan state encoding.
// Used by reg_file, the ALU and the VGA text renderer.
package datapath_pkg;

  parameter int unsigned DATA_W   = 16;
  parameter int unsigned ADDR_W   = 4;
  parameter int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    SCAN_IDLE,
    SCAN_RUN
  } scan_state_e;

endpackage

// File: rtl/reg_file_dbg_scan.sv
// Debug scan sequencer: on request, streams every register through registered dbg_* outputs,
// one index per cycle, reading the raw array through its own address port.
module reg_file_dbg_scan
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = datapath_pkg::DATA_W,
  parameter int unsigned ADDR_W = datapath_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_req,
  output logic [ADDR_W-1:0] scan_addr,
  input  logic [DATA_W-1:0] scan_rdata,
  output logic              dbg_busy,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    valid_d = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      SCAN_IDLE: begin
        if (dbg_req) begin
          state_d = SCAN_RUN;
          cnt_d   = '0;
        end
      end
      SCAN_RUN: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        idx_d   = cnt_q;
        data_d  = scan_rdata;
        // Counter wraps to 0 naturally after the last index.
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = SCAN_IDLE;
        end
      end
      default: state_d = SCAN_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign scan_addr = cnt_q;
  assign dbg_busy  = busy_q;
  assign dbg_valid = valid_q;
  assign dbg_idx   = idx_q;
  assign dbg_data  = data_q;

endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file with R0 tied to zero, write-through bypass on both
// read ports, a registered ALU flag and a debug scan port.
module reg_file
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = datapath_pkg::DATA_W,
  parameter int unsigned ADDR_W = datapath_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  input  logic              we,
  input  logic [ADDR_W-1:0] wd_addr,
  input  logic [DATA_W-1:0] wd,
  input  logic              flag_we,
  input  logic              flag_in,
  output logic              flag,
  input  logic              dbg_req,
  output logic              dbg_busy,
  output logic              dbg_valid,
  output logic [ADDR_W-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              flag_q, flag_d;
  logic [ADDR_W-1:0] scan_addr;
  logic              wr_en;

  assign wr_en = we && (wd_addr != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wd_addr] = wd;
    end
  end

  always_comb begin
    flag_d = flag_we ? flag_in : flag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      flag_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      flag_q <= flag_d;
    end
  end

  // Bypass only applies to nonzero addresses; R0 always reads zero.
  always_comb begin
    a = '0;
    if (ra_addr != '0) begin
      a = (wr_en && (wd_addr == ra_addr)) ? wd : mem_q[ra_addr];
    end
  end

  always_comb begin
    b = '0;
    if (rb_addr != '0) begin
      b = (wr_en && (wd_addr == rb_addr)) ? wd : mem_q[rb_addr];
    end
  end

  assign flag = flag_q;

  reg_file_dbg_scan #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dbg_scan (
    .clk        (clk),
    .rst        (rst),
    .dbg_req    (dbg_req),
    .scan_addr  (scan_addr),
    .scan_rdata (mem_q[scan_addr]),
    .dbg_busy   (dbg_busy),
    .dbg_valid  (dbg_valid),
    .dbg_idx    (dbg_idx),
    .dbg_data   (dbg_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, reads, bypass, R0, flag, debug scan and async reset.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [3:0]  ra_addr, rb_addr, wd_addr;
  logic [15:0] a, b, wd;
  logic        we, flag_we, flag_in, flag;
  logic        dbg_req, dbg_busy, dbg_valid;
  logic [3:0]  dbg_idx;
  logic [15:0] dbg_data;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  reg_file u_dut (
    .clk       (clk),
    .rst       (rst),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .a         (a),
    .b         (b),
    .we        (we),
    .wd_addr   (wd_addr),
    .wd        (wd),
    .flag_we   (flag_we),
    .flag_in   (flag_in),
    .flag      (flag),
    .dbg_req   (dbg_req),
    .dbg_busy  (dbg_busy),
    .dbg_valid (dbg_valid),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] adr, input logic [15:0] dat);
    @(negedge clk);
    we = 1'b1; wd_addr = adr; wd = dat;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ra_addr = '0; rb_addr = '0; wd_addr = '0; wd = '0; we = 1'b0;
    flag_we = 1'b0; flag_in = 1'b0; dbg_req = 1'b0;
    #1;
    chk("rst_flag", 32'(flag), 32'h0);
    chk("rst_valid", 32'(dbg_valid), 32'h0);
    chk("rst_busy", 32'(dbg_busy), 32'h0);
    chk("rst_idx", 32'(dbg_idx), 32'h0);
    chk("rst_data", 32'(dbg_data), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ra_addr = 4'(i); rb_addr = 4'(15 - i);
      #1;
      chk($sformatf("rst_a%0d", i), 32'(a), 32'h0);
      chk($sformatf("rst_b%0d", 15 - i), 32'(b), 32'h0);
    end

    // Operand reads
    wr(4'd3, 16'd15);
    wr(4'd5, 16'd11);
    ra_addr = 4'd3; rb_addr = 4'd5;
    #1;
    chk("rd_a_r3", 32'(a), 32'd15);
    chk("rd_b_r5", 32'(b), 32'd11);

    // R0 stays zero, including under bypass
    wr(4'd0, 16'hFFFF);
    ra_addr = 4'd0; rb_addr = 4'd0;
    #1;
    chk("r0_a", 32'(a), 32'h0);
    chk("r0_b", 32'(b), 32'h0);
    we = 1'b1; wd_addr = 4'd0; wd = 16'hFFFF;
    #1;
    chk("r0_bypass", 32'(a), 32'h0);

    // Bypass on both ports
    @(negedge clk);
    we = 1'b1; wd_addr = 4'd7; wd = 16'h1234; ra_addr = 4'd7; rb_addr = 4'd7;
    #1;
    chk("byp_a", 32'(a), 32'h1234);
    chk("byp_b", 32'(b), 32'h1234);
    @(negedge clk);
    we = 1'b0; wd = 16'h0;
    #1;
    chk("arr_a7", 32'(a), 32'h1234);
    chk("arr_b7", 32'(b), 32'h1234);

    // Flag capture and hold
    flag_we = 1'b1; flag_in = 1'b1;
    @(negedge clk);
    chk("flag_set", 32'(flag), 32'h1);
    flag_we = 1'b0; flag_in = 1'b0;
    @(negedge clk);
    chk("flag_hold", 32'(flag), 32'h1);

    // Asynchronous reset between edges
    ra_addr = 4'd3; rb_addr = 4'd7;
    #2 rst = 1'b1;
    #1;
    chk("arst_a", 32'(a), 32'h0);
    chk("arst_b", 32'(b), 32'h0);
    chk("arst_flag", 32'(flag), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Preload and first scan
    for (int k = 1; k < 16; k++) wr(4'(k), 16'(k * 16'h0101));
    @(negedge clk);
    dbg_req = 1'b1;
    @(negedge clk);
    dbg_req = 1'b0;
    chk("scan_pre_valid", 32'(dbg_valid), 32'h0);
    chk("scan_pre_busy", 32'(dbg_busy), 32'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("s1_valid%0d", i), 32'(dbg_valid), 32'h1);
      chk($sformatf("s1_busy%0d", i), 32'(dbg_busy), 32'h1);
      chk($sformatf("s1_idx%0d", i), 32'(dbg_idx), 32'(i));
      chk($sformatf("s1_data%0d", i), 32'(dbg_data), 32'(i * 16'h0101));
      if (i == 1) dbg_req = 1'b1;
      if (i == 2) dbg_req = 1'b0;
      if (i == 3) begin
        we = 1'b1; wd_addr = 4'd4; wd = 16'hBEEF;
      end
      if (i == 4) we = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("s1_post_valid%0d", i), 32'(dbg_valid), 32'h0);
      chk($sformatf("s1_post_busy%0d", i), 32'(dbg_busy), 32'h0);
    end

    // Second scan, new R4 value, reset at idx 9
    dbg_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("s2_idx%0d", i), 32'(dbg_idx), 32'(i));
      chk($sformatf("s2_data%0d", i), 32'(dbg_data),
          (i == 4) ? 32'hBEEF : 32'(i * 16'h0101));
    end
    #2 rst = 1'b1;
    #1;
    chk("s2_arst_valid", 32'(dbg_valid), 32'h0);
    chk("s2_arst_busy", 32'(dbg_busy), 32'h0);
    chk("s2_arst_idx", 32'(dbg_idx), 32'h0);
    dbg_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_valid !== 1'b0 || dbg_busy !== 1'b0) n_valid++;
    end
    chk("s2_stay_idle", 32'(n_valid), 32'h0);
    ra_addr = 4'd4;
    #1;
    chk("s2_arst_r4", 32'(a), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
